pc_sequencer: RTL and testbench

//  Owns the program counter and sequences next-PC selection for the single-cycle/multi-cycle MIPS core.

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_sequencer_branch_target_calc.sv | 22 ++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and defaults for the program counter sequencer
// Contents: sequencer state encoding (ST_RUN, ST_FLUSH), next-PC select codes,
// default reset PC / exception vector, and a word-alignment helper.
package pc_sequencer_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } seq_state_e;

    // NPC_HOLD covers stall cycles where the PC register keeps its value.
    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JR   = 3'd3,
        NPC_EXC  = 3'd4,
        NPC_HOLD = 3'd5
    } npc_sel_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_branch_target_calc.sv
// rtl/pc_sequencer_branch_target_calc.sv - combinational branch and jump target generation
// Ports:
//   pc_plus4_i   [31:0] address of the sequential successor instruction
//   imm_i        [15:0] signed branch offset in words
//   target_i     [25:0] jump word index
//   br_target_o  [31:0] pc_plus4_i + sign_extend(imm_i) * 4 (modulo 2^32)
//   j_target_o   [31:0] {pc_plus4_i[31:28], target_i, 2'b00}
module branch_target_calc (
    input  logic [31:0] pc_plus4_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] br_target_o,
    output logic [31:0] j_target_o
);

    logic [31:0] offset;

    assign offset      = {{14{imm_i[15]}}, imm_i, 2'b00};
    assign br_target_o = pc_plus4_i + offset;
    assign j_target_o  = {pc_plus4_i[31:28], target_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter register, next-PC select and redirect flush window
// Optional feature macro: PC_SEQ_EXC_EN (adds Exc input, Epc output, exception redirect).
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   Stall               hold PC this cycle
//   Branch, Zero        conditional branch, taken when both set
//   Jump, JumpReg       j/jal and jr decoded
//   Imm [15:0]          branch word offset; Target [25:0] jump word index
//   RegAddr [31:0]      jr source register value
//   Exc / Epc [31:0]    exception request / faulting PC (PC_SEQ_EXC_EN only)
//   PC [31:0]           current fetch address; PCPlus4 [31:0] = PC + 4
//   Flush / Valid       squash window after a taken redirect; Valid = !Flush
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [15:0] Imm,
    input  logic [25:0] Target,
    input  logic [31:0] RegAddr,
`ifdef PC_SEQ_EXC_EN
    input  logic        Exc,
    output logic [31:0] Epc,
`endif
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        Valid
);

    seq_state_e  state_q;
    logic [2:0]  cnt_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        flush_q;
    logic        exc_w;
    npc_sel_e    sel;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;

`ifdef PC_SEQ_EXC_EN
    logic [31:0] epc_q;
    assign exc_w = Exc;
    assign Epc   = epc_q;
`else
    assign exc_w = 1'b0;
`endif

    assign pc_plus4 = pc_q + 32'd4;
    assign PC       = pc_q;
    assign PCPlus4  = pc_plus4;
    assign Flush    = flush_q;
    assign Valid    = ~flush_q;

    branch_target_calc u_btc (
        .pc_plus4_i  (pc_plus4),
        .imm_i       (Imm),
        .target_i    (Target),
        .br_target_o (br_target),
        .j_target_o  (j_target)
    );

    // Exceptions outrank everything, including stalls; during a flush window
    // the control inputs are wrong-path and only Stall is obeyed.
    always_comb begin
        sel = NPC_SEQ;
        if (exc_w)
            sel = NPC_EXC;
        else if (state_q == ST_FLUSH)
            sel = Stall ? NPC_HOLD : NPC_SEQ;
        else if (Stall)
            sel = NPC_HOLD;
        else if (JumpReg)
            sel = NPC_JR;
        else if (Jump)
            sel = NPC_J;
        else if (Branch && Zero)
            sel = NPC_BR;

        pc_d = pc_plus4;
        case (sel)
            NPC_BR:   pc_d = br_target;
            NPC_J:    pc_d = j_target;
            NPC_JR:   pc_d = word_align(RegAddr);
            NPC_EXC:  pc_d = word_align(EXC_VECTOR);
            NPC_HOLD: pc_d = pc_q;
            default:  pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= word_align(RESET_PC);
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            flush_q <= 1'b0;
`ifdef PC_SEQ_EXC_EN
            epc_q   <= 32'd0;
`endif
        end else begin
            pc_q <= pc_d;
            case (sel)
                NPC_BR, NPC_J, NPC_JR, NPC_EXC: begin
                    state_q <= ST_FLUSH;
                    cnt_q   <= 3'(FLUSH_CYCLES);
                    flush_q <= 1'b1;
                end
                default: begin
                    // Bubbles are consumed even while stalled.
                    if (state_q == ST_FLUSH) begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_q <= ST_RUN;
                            flush_q <= 1'b0;
                        end
                    end
                end
            endcase
`ifdef PC_SEQ_EXC_EN
            if (sel == NPC_EXC)
                epc_q <= pc_q;
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
module tb_pc_sequencer;

    localparam int          FC    = 2;
    localparam logic [31:0] RSTPC = 32'h0000_0000;
    localparam logic [31:0] EXCV  = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0, Branch = 1'b0, Zero = 1'b0, Jump = 1'b0, JumpReg = 1'b0;
    logic [15:0] Imm = '0;
    logic [25:0] Target = '0;
    logic [31:0] RegAddr = '0;
    logic        Exc = 1'b0;
    logic [31:0] Epc;
    logic [31:0] PC, PCPlus4;
    logic        Flush, Valid;

    pc_sequencer #(.RESET_PC(RSTPC), .FLUSH_CYCLES(FC), .EXC_VECTOR(EXCV)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Branch(Branch), .Zero(Zero),
        .Jump(Jump), .JumpReg(JumpReg), .Imm(Imm), .Target(Target), .RegAddr(RegAddr),
`ifdef PC_SEQ_EXC_EN
        .Exc(Exc), .Epc(Epc),
`endif
        .PC(PC), .PCPlus4(PCPlus4), .Flush(Flush), .Valid(Valid)
    );

`ifndef PC_SEQ_EXC_EN
    assign Epc = 32'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural PC plus number of bubbles still owed.
    logic [31:0] m_pc = '0;
    int          m_left = 0;
    logic [31:0] m_epc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Applies one cycle of inputs at the negative edge and predicts the state after the next rising edge.
    task automatic cyc(input logic r, input logic st, input logic br, input logic z,
                       input logic j, input logic jr, input logic ex,
                       input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] ra);
        exp_t e;
        logic signed [31:0] off;
        logic [31:0] seq;
        @(negedge clk);
        reset = r; Stall = st; Branch = br; Zero = z; Jump = j; JumpReg = jr;
        Imm = imm; Target = tgt; RegAddr = ra;
`ifdef PC_SEQ_EXC_EN
        Exc = ex;
`else
        Exc = 1'b0;
`endif
        seq = m_pc + 32'd4;
        off = $signed(imm);
        if (r) begin
            m_pc = RSTPC; m_left = 0; m_epc = 0;
        end else if (Exc) begin
            m_epc = m_pc; m_pc = EXCV; m_left = FC;
        end else if (m_left > 0) begin
            m_left--;
            if (!st) m_pc = seq;
        end else if (st) begin
            m_pc = m_pc;
        end else if (jr) begin
            m_pc = ra - (ra % 4); m_left = FC;
        end else if (j) begin
            m_pc = (seq & 32'hF000_0000) + ({6'd0, tgt} * 4); m_left = FC;
        end else if (br && z) begin
            m_pc = seq + off * 4; m_left = FC;
        end else begin
            m_pc = seq;
        end
        e.pc = m_pc; e.flush = (m_left > 0); e.epc = m_epc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic do_jr(input logic [31:0] a);
        cyc(0, 0, 0, 0, 0, 1, 0, '0, '0, a);
    endtask

    // Monitor: outputs are presented every cycle; compare each against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", PC, e.pc);
                check("pcplus4", PCPlus4, e.pc + 32'd4);
                check("flush", {31'd0, Flush}, {31'd0, e.flush});
                check("valid", {31'd0, Valid}, {31'd0, !e.flush});
`ifdef PC_SEQ_EXC_EN
                check("epc", Epc, e.epc);
`endif
            end
        end
    end

    initial begin
        int wait_cyc;
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        idle(4);
        // Branch with offset -1 word at PC 0x100 returns to 0x100.
        do_jr(32'h0000_00F8);
        idle(FC);
        cyc(0, 0, 1, 1, 0, 0, 0, 16'hFFFF, '0, '0);
        idle(FC + 1);
        // Jump beats a simultaneous taken branch.
        do_jr(32'h1000_0034);
        idle(FC);
        cyc(0, 0, 1, 1, 1, 0, 0, 16'h0040, 26'h000_0010, '0);
        idle(FC + 1);
        // Stall masks a jump in RUN.
        do_jr(32'h0000_0018);
        idle(FC);
        repeat (3) cyc(0, 1, 0, 0, 1, 0, 0, '0, 26'h3FF_FFFF, '0);
        idle(2);
        // Stall inside the flush window still consumes bubbles; wrong-path jumps ignored.
        do_jr(32'h0000_0400);
        cyc(0, 1, 0, 0, 1, 0, 0, '0, 26'h123, '0);
        idle(FC + 1);
        // Wrap at the top of the address space, then misaligned jr.
        do_jr(32'hFFFF_FFF4);
        idle(FC);
        idle(1);
        do_jr(32'h0000_0203);
        // Reset during a flush window.
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        idle(2);
`ifdef PC_SEQ_EXC_EN
        do_jr(32'h0000_003C);
        idle(FC);
        cyc(0, 1, 0, 0, 0, 0, 1, '0, '0, '0);
        idle(FC + 1);
`endif
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rnd;
            rnd = $urandom;
            cyc(($urandom_range(0, 59) == 0), (rnd[2:0] == 3'd0), rnd[3], rnd[4],
                (rnd[7:5] == 3'd0), (rnd[10:8] == 3'd0),
`ifdef PC_SEQ_EXC_EN
                ($urandom_range(0, 39) == 0),
`else
                1'b0,
`endif
                16'($urandom), 26'($urandom), $urandom);
        end
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
